dna_reader: RTL
===============

DNA_READER -- requirements
Module: dna_reader

Interface
REQ-001 SHALL have parameter DIV, default 4, giving the clk cycles per dna_clk half-period (legal range 1..255).
REQ-002 SHALL have parameter DW, default 57, giving the DNA width in bits.
REQ-003 SHALL have port clk  input  1  system clock (125 MHz); all logic is on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port restart  input  1  single-cycle request to re-read the DNA; honoured only in DONE.
REQ-006 SHALL have port dna_dout  input  1  serial data from the DNA_PORT primitive.
REQ-007 SHALL have port dna_clk  output  1  clock to the DNA_PORT primitive.
REQ-008 SHALL have port dna_read  output  1  DNA_PORT READ (parallel load).
REQ-009 SHALL have port dna_shift  output  1  DNA_PORT SHIFT.
REQ-010 SHALL have port dna_value  output  DW  captured DNA, presented to the ID register file.
REQ-011 SHALL have port dna_done  output  1  high while dna_value is valid and the reader is idle.

Function
REQ-012 SHALL implement states READ, SHIFT and DONE, with all outputs registered.
REQ-013 SHALL keep a divider counter cnt (0..DIV-1); cnt counts only in READ and SHIFT; at cnt==DIV-1 it wraps to 0 and dna_clk toggles.
REQ-014 SHALL hold dna_clk at 0 in DONE, so dna_clk has period 2*DIV clk cycles and starts low on entry to READ.
REQ-015 READ: dna_read=1 and dna_shift=0; the clk edge that drives dna_clk 1->0 samples dna_dout into the shift register, sets the bit counter to 1 and moves to SHIFT with dna_read=0 and dna_shift=1.
REQ-016 SHIFT: each clk edge that drives dna_clk 1->0 samples dna_dout and increments the bit counter.
REQ-017 SHALL capture MSB first: the shift register loads as {sr[DW-2:0], dna_dout}, so the first sampled bit ends in bit DW-1.
REQ-018 On the sample where the bit counter reaches DW, the same edge SHALL: load dna_value from the completed shift register, set dna_done=1, clear dna_shift, force dna_clk to 0, reset cnt and enter DONE.
REQ-019 dna_read and dna_shift SHALL never be high at the same time.
REQ-020 Exactly one dna_clk rising edge SHALL occur with dna_read=1, followed by exactly DW-1 rising edges with dna_shift=1, per read.
REQ-021 Latency: dna_done SHALL rise on the 2*DW*DIV-th clk rising edge after entry to READ (456 for the defaults).
REQ-022 DONE with restart=1: on the next edge SHALL enter READ with cnt=0, bit counter=0, dna_done=0; dna_value SHALL keep its old value until the new read completes.
REQ-023 restart in READ or SHIFT SHALL be ignored, with no effect on timing or data.
REQ-024 dna_value SHALL change only on the completion edge of REQ-018.

Reset
REQ-025 rstn low SHALL immediately force: state=READ, cnt=0, bit counter=0, shift register=0, dna_clk=0, dna_read=1, dna_shift=0, dna_value=0, dna_done=0.
REQ-026 After rstn deasserts, a read SHALL start automatically with no restart needed; rstn asserted mid-read SHALL abort it and the read SHALL restart from the beginning after release.

Verification
REQ-027 Reset release, DNA_PORT model loaded with 57'h0823456789ABCDE, defaults -> dna_done rises on edge 456 after release and dna_value=57'h0823456789ABCDE.
REQ-028 Protocol monitor during a read -> 1 dna_clk rise with dna_read=1, then 56 rises with dna_shift=1, dna_clk period 8 clk cycles, read and shift never overlap.
REQ-029 restart pulsed at edges 100 and 300 of a read -> both ignored and completion stays at edge 456; restart pulsed in DONE -> dna_done=0 on the next edge, old value held, re-asserted 456 edges later.
REQ-030 Model value changed to 57'h1FFFFFFFFFFFFFF followed by restart -> dna_value holds 57'h0823456789ABCDE until completion, then becomes 57'h1FFFFFFFFFFFFFF.
REQ-031 rstn pulsed low at edge 200 of a read -> outputs take their reset values asynchronously, and the full read completes 456 edges after release with the correct value.
REQ-032 DIV=1 -> dna_clk toggles every clk cycle and dna_done rises 114 edges after release with the correct value.

Source files
------------

// File: rtl/dna_reader.sv
// Serial reader for the DNA_PORT primitive. It generates the primitive's clock, pulses READ
// to load the shift chain, shifts DW bits out MSB first and then holds the captured value.
module dna_reader #(
   parameter int DIV = 4,
   parameter int DW  = 57
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          restart,
   input  logic          dna_dout,
   output logic          dna_clk,
   output logic          dna_read,
   output logic          dna_shift,
   output logic [DW-1:0] dna_value,
   output logic          dna_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = $clog2(DW + 1);

   typedef enum logic [1:0] {READ, SHIFT, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [BW-1:0] bits;
   logic [DW-1:0] sr;
   logic          tick;
   logic          fall;

   // dna_dout is sampled on the edge that drives dna_clk low, giving the primitive a full
   // half-period after its rising edge to present the next bit.
   assign tick = (cnt == CW'(DIV - 1));
   assign fall = tick && dna_clk;

   // NOTE: every register here, including the shift register, is reset and updated with
   // non-blocking assignments so all outputs change together on one edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= READ;
         cnt       <= '0;
         bits      <= '0;
         sr        <= '0;
         dna_clk   <= 1'b0;
         dna_read  <= 1'b1;
         dna_shift <= 1'b0;
         dna_value <= '0;
         dna_done  <= 1'b0;
      end else begin
         if (state != DONE) begin
            if (tick) begin
               cnt     <= '0;
               dna_clk <= ~dna_clk;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end

         case (state)
            READ: begin
               if (fall) begin
                  sr        <= {sr[DW-2:0], dna_dout};
                  bits      <= BW'(1);
                  dna_read  <= 1'b0;
                  dna_shift <= 1'b1;
                  state     <= SHIFT;
               end
            end

            SHIFT: begin
               if (fall) begin
                  sr   <= {sr[DW-2:0], dna_dout};
                  bits <= bits + 1'b1;
                  if (bits == BW'(DW - 1)) begin
                     dna_value <= {sr[DW-2:0], dna_dout};
                     dna_done  <= 1'b1;
                     dna_shift <= 1'b0;
                     dna_clk   <= 1'b0;
                     cnt       <= '0;
                     state     <= DONE;
                  end
               end
            end

            DONE: begin
               // dna_value is deliberately left alone so it stays valid until the next read ends
               if (restart) begin
                  cnt      <= '0;
                  bits     <= '0;
                  dna_clk  <= 1'b0;
                  dna_read <= 1'b1;
                  dna_done <= 1'b0;
                  state    <= READ;
               end
            end

            default: state <= READ;
         endcase
      end
   end

endmodule
